// File: rtl/sd_read_sector.sv
// SPI-mode SD single-sector reader: CMD17, wait R1 and start token, stream 256 16-bit words,
// drop CRC, then clock TAIL_CLKS cycles with CS high before going idle.
module sd_read_sector #(
    parameter int          CLK_DIV       = 2,
    parameter int          RESP_TIMEOUT  = 16,
    parameter logic [15:0] TOKEN_TIMEOUT = 16'd5000,
    parameter int          TAIL_CLKS     = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_done,
    input  logic        rd_start_en,
    input  logic [31:0] rd_sec_addr,
    output logic        rd_busy,
    output logic        rd_val_en,
    output logic [15:0] rd_val_data,
    output logic        rd_err,
    output logic        sd_cs,
    output logic        sd_sclk,
    input  logic        sd_miso,
    output logic        sd_mosi
);
    typedef enum logic [2:0] {IDLE, CMD, RESP, TOKEN, DATA, CRC, ERR, TAIL} state_t;

    localparam int         DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [7:0] CMD17 = 8'h51;

    state_t           state;
    logic [31:0]      addr;
    logic [2:0]       cmd_idx;
    logic [15:0]      poll_cnt;
    logic [8:0]       byte_idx;
    logic [7:0]       hold;
    logic             running;
    logic [DIV_W-1:0] div_cnt;
    logic [7:0]       bit_cnt;
    logic [7:0]       tx_sr;
    logic [7:0]       rx_sr;
    logic [7:0]       cmd_next;
    logic [7:0]       last_bit;
    logic             done;

    // TAIL counts raw sclk cycles instead of whole bytes
    assign last_bit = (state == TAIL) ? 8'(TAIL_CLKS - 1) : 8'd7;
    assign done     = running && sd_sclk && (div_cnt == DIV_W'(CLK_DIV - 1)) && (bit_cnt == last_bit);

    always_comb begin
        cmd_next = 8'hFF;
        case (cmd_idx)
            3'd0:    cmd_next = addr[31:24];
            3'd1:    cmd_next = addr[23:16];
            3'd2:    cmd_next = addr[15:8];
            3'd3:    cmd_next = addr[7:0];
            default: cmd_next = 8'hFF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            cmd_idx     <= '0;
            poll_cnt    <= '0;
            byte_idx    <= '0;
            hold        <= '0;
            running     <= 1'b0;
            div_cnt     <= '0;
            bit_cnt     <= '0;
            tx_sr       <= 8'hFF;
            rx_sr       <= '0;
            rd_busy     <= 1'b0;
            rd_val_en   <= 1'b0;
            rd_val_data <= '0;
            rd_err      <= 1'b0;
            sd_cs       <= 1'b1;
            sd_sclk     <= 1'b0;
            sd_mosi     <= 1'b1;
        end else begin
            rd_val_en <= 1'b0;
            rd_err    <= 1'b0;

            // Byte engine: free-runs back to back, reloading 0xFF after every byte unless overridden below
            if (running) begin
                if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                    div_cnt <= '0;
                    sd_sclk <= ~sd_sclk;
                    if (!sd_sclk) begin
                        rx_sr <= {rx_sr[6:0], sd_miso};
                    end else if (bit_cnt == last_bit) begin
                        bit_cnt <= '0;
                        sd_mosi <= 1'b1;
                        tx_sr   <= 8'hFF;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                        sd_mosi <= tx_sr[7];
                        tx_sr   <= {tx_sr[6:0], 1'b1};
                    end
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end
            end

            case (state)
                IDLE: if (rd_start_en && init_done && !rd_busy) begin
                    addr    <= rd_sec_addr;
                    rd_busy <= 1'b1;
                    sd_cs   <= 1'b0;
                    cmd_idx <= '0;
                    running <= 1'b1;
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    sd_mosi <= CMD17[7];
                    tx_sr   <= {CMD17[6:0], 1'b1};
                    state   <= CMD;
                end
                CMD: if (done) begin
                    if (cmd_idx == 3'd5) begin
                        poll_cnt <= '0;
                        state    <= RESP;
                    end else begin
                        cmd_idx <= cmd_idx + 3'd1;
                        sd_mosi <= cmd_next[7];
                        tx_sr   <= {cmd_next[6:0], 1'b1};
                    end
                end
                RESP: if (done) begin
                    if (rx_sr == 8'h00) begin
                        poll_cnt <= '0;
                        state    <= TOKEN;
                    end else if (rx_sr != 8'hFF || poll_cnt == 16'(RESP_TIMEOUT - 1)) begin
                        running <= 1'b0;
                        state   <= ERR;
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                    end
                end
                TOKEN: if (done) begin
                    if (rx_sr == 8'hFE) begin
                        poll_cnt <= '0;
                        byte_idx <= '0;
                        state    <= DATA;
                    end else if (rx_sr != 8'hFF || poll_cnt == TOKEN_TIMEOUT - 16'd1) begin
                        running <= 1'b0;
                        state   <= ERR;
                    end else begin
                        poll_cnt <= poll_cnt + 16'd1;
                    end
                end
                DATA: if (done) begin
                    byte_idx <= byte_idx + 9'd1;
                    if (!byte_idx[0]) begin
                        hold <= rx_sr;
                    end else begin
                        rd_val_data <= {hold, rx_sr};
                        rd_val_en   <= 1'b1;
                    end
                    if (byte_idx == 9'd511) begin
                        poll_cnt <= '0;
                        state    <= CRC;
                    end
                end
                CRC: if (done) begin
                    poll_cnt <= poll_cnt + 16'd1;
                    if (poll_cnt == 16'd1) begin
                        sd_cs    <= 1'b1;
                        poll_cnt <= '0;
                        state    <= TAIL;
                    end
                end
                ERR: begin
                    rd_err   <= 1'b1;
                    sd_cs    <= 1'b1;
                    running  <= 1'b1;
                    div_cnt  <= '0;
                    bit_cnt  <= '0;
                    sd_mosi  <= 1'b1;
                    tx_sr    <= 8'hFF;
                    poll_cnt <= '0;
                    state    <= TAIL;
                end
                TAIL: if (done) begin
                    running <= 1'b0;
                    rd_busy <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sd_read_sector.sv
// Bench for sd_read_sector: byte-level SD card model on the SPI pins plus a queue-based
// reference of the expected command bytes, words, error position and tail clocks.
module tb_sd_read_sector;
    localparam int          CLK_DIV  = 1;
    localparam int          RESP_TO  = 16;
    localparam logic [15:0] TOKEN_TO = 16'd300;
    localparam int          TAIL     = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        init_done = 1'b0;
    logic        rd_start_en = 1'b0;
    logic [31:0] rd_sec_addr = '0;
    logic        rd_busy, rd_val_en, rd_err, sd_cs, sd_sclk, sd_miso, sd_mosi;
    logic [15:0] rd_val_data;

    int checks = 0;
    int errors = 0;

    sd_read_sector #(
        .CLK_DIV(CLK_DIV), .RESP_TIMEOUT(RESP_TO), .TOKEN_TIMEOUT(TOKEN_TO), .TAIL_CLKS(TAIL)
    ) dut (
        .clk(clk), .rst(rst), .init_done(init_done), .rd_start_en(rd_start_en),
        .rd_sec_addr(rd_sec_addr), .rd_busy(rd_busy), .rd_val_en(rd_val_en),
        .rd_val_data(rd_val_data), .rd_err(rd_err), .sd_cs(sd_cs), .sd_sclk(sd_sclk),
        .sd_miso(sd_miso), .sd_mosi(sd_mosi)
    );

    always #5 clk = ~clk;

    // Card model: byte i of miso_q answers host byte i after CS falls; then 0xFF
    logic [7:0]  miso_q[$];
    logic [7:0]  mosi_log[$];
    logic [7:0]  out_byte = 8'hFF;
    logic [7:0]  rxb = 8'h00;
    logic [2:0]  bp = 3'd0;
    logic        pcs = 1'b1, psclk = 1'b0;
    int          mi = 0, rbits = 0, tail_clk = 0;

    assign sd_miso = (sd_cs === 1'b0) ? out_byte[3'd7 - bp] : 1'b1;

    function automatic logic [7:0] card_byte(input int i);
        return (i < miso_q.size()) ? miso_q[i] : 8'hFF;
    endfunction

    always @(sd_cs or sd_sclk) begin
        if (pcs !== 1'b0 && sd_cs === 1'b0) begin
            mi = 0; bp = 3'd0; rbits = 0; out_byte = card_byte(0);
        end else if (psclk === 1'b0 && sd_sclk === 1'b1) begin
            if (sd_cs === 1'b1) tail_clk++;
            else begin
                rxb = {rxb[6:0], sd_mosi};
                if (rbits == 7) begin rbits = 0; mosi_log.push_back(rxb); end
                else rbits++;
            end
        end else if (psclk === 1'b1 && sd_sclk === 1'b0 && sd_cs === 1'b0) begin
            if (bp == 3'd7) begin bp = 3'd0; mi++; out_byte = card_byte(mi); end
            else bp = bp + 3'd1;
        end
        pcs = sd_cs;
        psclk = sd_sclk;
    end

    // Output monitor
    logic [15:0] got_q[$];
    int   cyc = 0, last_pulse = -1000, gap_bad = 0, err_cnt = 0, err_pos = 0, fall_cnt = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (rd_val_en === 1'b1) begin
            got_q.push_back(rd_val_data);
            if (cyc - last_pulse < 16 * CLK_DIV) gap_bad++;
            last_pulse = cyc;
        end
        if (rd_err === 1'b1) begin err_cnt++; err_pos = mosi_log.size(); end
        if (prev_busy === 1'b1 && rd_busy === 1'b0) fall_cnt++;
        prev_busy = rd_busy;
    end

    logic [15:0] exp_q[$];
    int b_log, b_got, b_err, b_fall, b_tail, b_gap;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic snap();
        b_log = mosi_log.size(); b_got = got_q.size(); b_err = err_cnt;
        b_fall = fall_cnt; b_tail = tail_clk; b_gap = gap_bad;
        exp_q.delete();
    endtask

    task automatic load_card(input int d_r, input logic [7:0] r1, input int d_t, input bit tok, input bit ramp);
        logic [7:0] pl [512];
        miso_q.delete();
        for (int k = 0; k < 512; k++) pl[k] = ramp ? 8'(k) : 8'($urandom);
        for (int k = 0; k < 6 + d_r; k++) miso_q.push_back(8'hFF);
        miso_q.push_back(r1);
        if (r1 == 8'h00) begin
            for (int k = 0; k < d_t; k++) miso_q.push_back(8'hFF);
            if (tok) begin
                miso_q.push_back(8'hFE);
                for (int k = 0; k < 512; k++) miso_q.push_back(pl[k]);
                miso_q.push_back(8'($urandom));
                miso_q.push_back(8'($urandom));
                for (int w = 0; w < 256; w++) exp_q.push_back({pl[2*w], pl[2*w+1]});
            end
        end
    endtask

    task automatic start_req(input logic [31:0] a);
        rd_sec_addr = a;
        rd_start_en = 1'b1;
        tick();
        rd_start_en = 1'b0;
    endtask

    task automatic wait_done(input int maxc);
        int n;
        n = 0;
        while (rd_busy === 1'b1 && n < maxc) begin tick(); n++; end
        if (n >= maxc) chk("busy_timeout", 32'(rd_busy), 32'd0);
    endtask

    task automatic wait_words(input int target, input int maxc);
        int n;
        n = 0;
        while (got_q.size() < target && n < maxc) begin tick(); n++; end
        if (n >= maxc) chk("words_timeout", 32'(got_q.size()), 32'(target));
    endtask

    task automatic check_sector(input logic [31:0] a, input int exp_err, input int exp_pos);
        logic [7:0] cmd [6];
        int nlog, extra, ngot;
        cmd[0] = 8'h51; cmd[1] = a[31:24]; cmd[2] = a[23:16];
        cmd[3] = a[15:8]; cmd[4] = a[7:0]; cmd[5] = 8'hFF;
        nlog = mosi_log.size() - b_log;
        for (int i = 0; i < 6; i++)
            chk($sformatf("cmd_byte%0d", i), (i < nlog) ? 32'(mosi_log[b_log+i]) : 32'hX, 32'(cmd[i]));
        extra = 0;
        for (int i = b_log + 6; i < mosi_log.size(); i++) if (mosi_log[i] != 8'hFF) extra++;
        chk("mosi_non_ff_after_cmd", 32'(extra), 32'd0);
        ngot = got_q.size() - b_got;
        chk("word_count", 32'(ngot), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < ngot; i++)
            chk($sformatf("word%0d", i), 32'(got_q[b_got+i]), 32'(exp_q[i]));
        chk("err_pulses", 32'(err_cnt - b_err), 32'(exp_err));
        if (exp_err != 0) chk("err_byte_pos", 32'(err_pos - b_log), 32'(exp_pos));
        chk("busy_falls", 32'(fall_cnt - b_fall), 32'd1);
        chk("tail_clks", 32'(tail_clk - b_tail), 32'(TAIL));
        chk("pulse_gap", 32'(gap_bad - b_gap), 32'd0);
    endtask

    initial begin
        int busy_hi, cs_lo, d_r, d_t, total;
        logic [31:0] a;

        #2 rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(rd_busy), 32'd0);
        chk("rst_val_en", 32'(rd_val_en), 32'd0);
        chk("rst_val_data", 32'(rd_val_data), 32'd0);
        chk("rst_err", 32'(rd_err), 32'd0);
        chk("rst_cs", 32'(sd_cs), 32'd1);
        chk("rst_sclk", 32'(sd_sclk), 32'd0);
        chk("rst_mosi", 32'(sd_mosi), 32'd1);
        rst = 1'b0;
        tick();

        // start while not initialised
        start_req(32'd7);
        busy_hi = 0; cs_lo = 0;
        repeat (40) begin tick(); busy_hi += int'(rd_busy); cs_lo += int'(!sd_cs); end
        chk("noinit_busy", 32'(busy_hi), 32'd0);
        chk("noinit_cs", 32'(cs_lo), 32'd0);
        init_done = 1'b1;
        tick();

        // nominal sector with a colliding start mid-DATA
        snap();
        load_card(2, 8'h00, 10, 1'b1, 1'b1);
        start_req(32'd16448);
        wait_words(b_got + 50, 20000);
        start_req(32'hDEAD_BEEF);
        wait_done(20000);
        check_sector(32'd16448, 0, 0);
        if (got_q.size() >= b_got + 256) begin
            chk("nom_word0", 32'(got_q[b_got]), 32'h0001);
            chk("nom_word255", 32'(got_q[b_got+255]), 32'hFEFF);
        end else chk("nom_words_present", 32'(got_q.size() - b_got), 32'd256);

        // back-to-back sectors, each restarted the cycle after busy falls
        tick();
        total = 0;
        snap();
        load_card(int'($urandom_range(0, 8)), 8'h00, int'($urandom_range(0, 20)), 1'b1, 1'b0);
        start_req(32'd18752);
        for (int s = 0; s < 3; s++) begin
            wait_done(20000);
            check_sector(32'd18752 + 32'(s), 0, 0);
            total += got_q.size() - b_got;
            if (s < 2) begin
                snap();
                load_card(int'($urandom_range(0, 8)), 8'h00, int'($urandom_range(0, 20)), 1'b1, 1'b0);
                start_req(32'd18753 + 32'(s));
            end
        end
        chk("b2b_total_words", 32'(total), 32'd768);

        // R1 error
        tick();
        snap();
        d_r = int'($urandom_range(0, 8));
        a = $urandom;
        load_card(d_r, 8'h04, 0, 1'b0, 1'b0);
        start_req(a);
        wait_done(4000);
        check_sector(a, 1, 6 + d_r + 1);

        // start token never arrives
        tick();
        snap();
        d_r = int'($urandom_range(0, 8));
        a = $urandom;
        load_card(d_r, 8'h00, 0, 1'b0, 1'b0);
        start_req(a);
        wait_done(20000);
        check_sector(a, 1, 6 + d_r + 1 + int'(TOKEN_TO));

        // reset during word 100, then a clean sector
        tick();
        snap();
        load_card(int'($urandom_range(0, 8)), 8'h00, int'($urandom_range(0, 20)), 1'b1, 1'b0);
        start_req($urandom);
        wait_words(b_got + 100, 20000);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(rd_busy), 32'd0);
        chk("mid_rst_val_en", 32'(rd_val_en), 32'd0);
        chk("mid_rst_val_data", 32'(rd_val_data), 32'd0);
        chk("mid_rst_err", 32'(rd_err), 32'd0);
        chk("mid_rst_cs", 32'(sd_cs), 32'd1);
        chk("mid_rst_sclk", 32'(sd_sclk), 32'd0);
        chk("mid_rst_mosi", 32'(sd_mosi), 32'd1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) tick();
        chk("mid_rst_no_err_pulse", 32'(err_cnt - b_err), 32'd0);
        snap();
        d_t = int'($urandom_range(0, 20));
        a = $urandom;
        load_card(int'($urandom_range(0, 8)), 8'h00, d_t, 1'b1, 1'b0);
        start_req(a);
        wait_done(20000);
        check_sector(a, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
